// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Fetch-stage program counter for a five-stage MIPS-style pipeline. Holds the
// current fetch address and tracks whether that fetch is in a branch delay
// slot. It raises a registered address-error flag for illegal fetch
// addresses and redirects to the exception handler or to the EPC when asked.
//
// Optional feature (compile-time macro):
//   PC_FETCH_CNT_EN  defined   -> fetch_cnt counts accepted fetches
//                    undefined -> fetch_cnt is tied to 0 (no counter logic)
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high reset
//   stall        in   1   D-stage hazard stall; holds the PC while in RUN
//   npc_in       in  32   next PC from the next-PC calculator
//   jump_taken   in   1   D-stage instr is a branch/jump; next fetch is a slot
//   exc_req      in   1   exception/interrupt accepted; go to handler
//   eret_req     in   1   eret committed; go to epc
//   epc          in  32   eret return address
//   pc_out       out 32   current fetch address (registered)
//   pc4_out      out 32   pc_out + 4 (mod 2^32)
//   pc_bd        out  1   current fetch is a branch delay slot (registered)
//   fetch_valid  out  1   current fetch is real (low = bubble)
//   fetch_adel   out  1   current fetch address is illegal (registered)
//   fetch_cnt    out 32   number of accepted fetches
// ---------------------------------------------------------------------------
module pc_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc_in,
  input  logic        jump_taken,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic        pc_bd,
  output logic        fetch_valid,
  output logic        fetch_adel,
  output logic [31:0] fetch_cnt
);

  // FSM encoding
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  // Fixed addresses and the legal instruction-memory window
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI    = 32'h0000_6FFC;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic        adel_q, adel_d;
  logic        advance;

  // -------------------------------------------------------------------------
  // Next-state / next-PC selection. exc_req wins over eret_req, and both
  // win over stall; in BOOT and REDIR the D stage holds no meaningful
  // instruction, so its stall and jump_taken are ignored.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = RUN;
    pc_d    = npc_in;
    bd_d    = 1'b0;
    advance = 1'b1;

    if (exc_req) begin
      state_d = REDIR;
      pc_d    = HANDLER_PC;
    end else if (eret_req) begin
      state_d = REDIR;
      pc_d    = epc;
    end else begin
      case (state_q)
        RUN: begin
          if (stall) begin
            pc_d    = pc_q;
            bd_d    = bd_q;
            advance = 1'b0;
          end else begin
            bd_d = jump_taken;
          end
        end
        default: begin
          // BOOT, REDIR (and the unused encoding) fall through to RUN with
          // the defaults: take npc_in, not a delay slot.
        end
      endcase
    end
  end

  // Address error is judged on the address about to be fetched and then
  // registered alongside it, so it lines up with pc_out.
  always_comb begin
    adel_d = (pc_d[1:0] != 2'b00) || (pc_d < IMEM_LO) || (pc_d > IMEM_HI);
  end

  // -------------------------------------------------------------------------
  // State registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      bd_q    <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      adel_q  <= adel_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc4_out     = pc_q + 32'd4;  // natural 32-bit wrap
  assign pc_bd       = bd_q;
  assign fetch_adel  = adel_q;
  assign fetch_valid = (state_q != BOOT);

`ifdef PC_FETCH_CNT_EN
  // Counts edges where a real fetch is consumed: the current fetch is valid
  // and the PC either moves on or is redirected.
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (fetch_valid && advance) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = cnt_q;
`else
  assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed scoreboard bench for pc_fetch_unit. Each step drives one cycle of
// inputs, pushes the expected post-edge outputs into a queue, and after the
// edge pops the entry and compares it to the DUT outputs.
// The expected fetch count follows PC_FETCH_CNT_EN the same way as the DUT.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] npc_in;
  logic        jump_taken;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        pc_bd;
  logic        fetch_valid;
  logic        fetch_adel;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        bd;
    logic        valid;
    logic        adel;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_cnt = '0;

  pc_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_in      (npc_in),
    .jump_taken  (jump_taken),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pc_out      (pc_out),
    .pc4_out     (pc4_out),
    .pc_bd       (pc_bd),
    .fetch_valid (fetch_valid),
    .fetch_adel  (fetch_adel),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Watchdog: the run is short; if it ever stalls, report and stop.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One clock of stimulus. 'counted' says whether this edge consumes a real
  // fetch (valid fetch that advances or redirects).
  task automatic step(input string tag, input logic rst, input logic stl,
                      input logic [31:0] npc, input logic jt,
                      input logic exc, input logic eret, input logic [31:0] ep,
                      input logic [31:0] e_pc, input logic [31:0] e_pc4,
                      input logic e_bd, input logic e_valid,
                      input logic e_adel, input logic counted);
    exp_t e;
    exp_t got;
    reset      = rst;
    stall      = stl;
    npc_in     = npc;
    jump_taken = jt;
    exc_req    = exc;
    eret_req   = eret;
    epc        = ep;

`ifdef PC_FETCH_CNT_EN
    if (rst)          exp_cnt = '0;
    else if (counted) exp_cnt = exp_cnt + 32'd1;
`else
    exp_cnt = '0;
`endif

    e.tag   = tag;
    e.pc    = e_pc;
    e.pc4   = e_pc4;
    e.bd    = e_bd;
    e.valid = e_valid;
    e.adel  = e_adel;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check({got.tag, ".pc_out"},      pc_out,             got.pc);
      check({got.tag, ".pc4_out"},     pc4_out,            got.pc4);
      check({got.tag, ".pc_bd"},       {31'd0, pc_bd},      {31'd0, got.bd});
      check({got.tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, got.valid});
      check({got.tag, ".fetch_adel"},  {31'd0, fetch_adel},  {31'd0, got.adel});
      check({got.tag, ".fetch_cnt"},   fetch_cnt,          got.cnt);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_in = '0; jump_taken = 1'b0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;

    // Reset for two cycles, then the one-cycle BOOT bubble.
    step("rst0", 1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h3000, 32'h3004, 0, 0, 0, 0);
    step("rst1", 1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h3000, 32'h3004, 0, 0, 0, 0);
    step("boot", 0, 1, 32'h3004, 1, 0, 0, 32'h0, 32'h3004, 32'h3008, 0, 1, 0, 0);

    // Delay slot, then three stalled cycles hold pc and pc_bd.
    step("jump",   0, 0, 32'h3010, 1, 0, 0, 32'h0, 32'h3010, 32'h3014, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, 32'h3020, 0, 0, 0, 32'h0, 32'h3010, 32'h3014, 1, 1, 0, 0);

    // Exception and eret together during a stall: exception wins.
    step("exc_eret", 0, 1, 32'h3030, 1, 1, 1, 32'h3404, 32'h4180, 32'h4184, 0, 1, 0, 1);
    // REDIR ignores stall and jump_taken.
    step("redir",    0, 1, 32'h3040, 1, 0, 0, 32'h0, 32'h3040, 32'h3044, 0, 1, 0, 1);

    // eret targets, including misaligned and above-window addresses.
    step("eret",      0, 1, 32'h3050, 1, 0, 1, 32'h3404, 32'h3404, 32'h3408, 0, 1, 0, 1);
    step("eret_mis",  0, 0, 32'h3050, 0, 0, 1, 32'h3402, 32'h3402, 32'h3406, 0, 1, 1, 1);
    step("eret_high", 0, 0, 32'h3050, 0, 0, 1, 32'h7000, 32'h7000, 32'h7004, 0, 1, 1, 1);

    // Window edges: last legal word, just below the window, wrap address.
    step("hi_edge",  0, 0, 32'h6FFC, 1, 0, 0, 32'h0, 32'h6FFC, 32'h7000, 0, 1, 0, 1);
    step("lo_edge",  0, 0, 32'h2FFC, 0, 0, 0, 32'h0, 32'h2FFC, 32'h3000, 0, 1, 1, 1);
    step("lo_ok",    0, 0, 32'h3000, 1, 0, 0, 32'h0, 32'h3000, 32'h3004, 1, 1, 0, 1);
    step("wrap",     0, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000, 0, 1, 1, 1);

    // Reset mid-stall with a competing exception.
    step("rst_stall", 1, 1, 32'h3100, 1, 1, 0, 32'h0, 32'h3000, 32'h3004, 0, 0, 0, 0);
    step("boot2",     0, 0, 32'h3004, 0, 0, 0, 32'h0, 32'h3004, 32'h3008, 0, 1, 0, 0);

    // Reset mid-REDIR.
    step("exc2",      0, 0, 32'h3008, 0, 1, 0, 32'h0, 32'h4180, 32'h4184, 0, 1, 0, 1);
    step("rst_redir", 1, 0, 32'h3200, 0, 0, 1, 32'h3404, 32'h3000, 32'h3004, 0, 0, 0, 0);

    // Counter: BOOT, ten unstalled fetches, two stalled cycles.
    step("boot3", 0, 0, 32'h3004, 0, 0, 0, 32'h0, 32'h3004, 32'h3008, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      a = 32'h3008 + 32'(i * 4);
      step("run", 0, 0, a, 0, 0, 0, 32'h0, a, a + 32'd4, 0, 1, 0, 1);
    end
    for (int i = 0; i < 2; i++)
      step("cnt_stall", 0, 1, 32'h3500, 0, 0, 0, 32'h0, 32'h302C, 32'h3030, 0, 1, 0, 0);

`ifdef PC_FETCH_CNT_EN
    check("cnt_final", fetch_cnt, 32'd10);
`else
    check("cnt_final", fetch_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL provide these ports, clock and reset first (name, direction, width, meaning):
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hazard stall from the D stage; when high, hold the fetch PC.
REQ-005 npc_in  input  32  next-PC value from the next-PC calculator.
REQ-006 jump_taken  input  1  D-stage instruction is a branch or jump, so the next fetch is a delay slot.
REQ-007 exc_req  input  1  exception or interrupt accepted; redirect to the handler.
REQ-008 eret_req  input  1  eret committed; redirect to the EPC.
REQ-009 epc  input  32  return address for eret.
REQ-010 pc_out  output  32  current fetch address (registered).
REQ-011 pc4_out  output  32  pc_out + 4, fed to the next-PC calculator.
REQ-012 pc_bd  output  1  current fetch is in a branch delay slot (registered).
REQ-013 fetch_valid  output  1  current fetch is real; low means it is a bubble.
REQ-014 fetch_adel  output  1  fetch address error (registered).
REQ-015 fetch_cnt  output  32  count of accepted fetches.

Function
REQ-016 The FSM SHALL have three states, BOOT, RUN and REDIR, with these outputs:
- BOOT: fetch_valid=0.
- RUN and REDIR: fetch_valid=1.
REQ-017 State transitions SHALL be:
- BOOT->RUN after exactly one cycle.
- RUN->REDIR on exc_req or eret_req.
- REDIR->REDIR on exc_req or eret_req.
- REDIR->RUN otherwise.
REQ-018 Next-PC priority SHALL be, highest first: reset, exc_req, eret_req, stall, normal.
REQ-019 exc_req SHALL set pc<=0x0000_4180 and pc_bd<=0, regardless of stall, eret_req or state.
REQ-020 eret_req without exc_req SHALL set pc<=epc and pc_bd<=0, regardless of stall.
REQ-021 In RUN, stall=1 SHALL hold pc and pc_bd unchanged.
REQ-022 In RUN, stall=0 SHALL set pc<=npc_in and pc_bd<=jump_taken.
REQ-023 In BOOT and REDIR, without exc_req or eret_req, the block SHALL ignore stall and jump_taken, set pc<=npc_in and set pc_bd<=0.
REQ-024 pc4_out SHALL equal pc_out+4, computed modulo 2^32 (0xFFFF_FFFC yields 0x0000_0000).
REQ-025 fetch_adel SHALL be computed from the next-PC value and registered, so it aligns with pc_out.
REQ-026 fetch_adel SHALL be 1 when pc[1:0]!=0, or when pc<0x0000_3000, or when pc>0x0000_6FFC; otherwise 0.
REQ-027 fetch_adel SHALL NOT alter PC sequencing; the exception arrives later via exc_req.
REQ-028 exc_req and eret_req asserted together SHALL be treated as exc_req only.
REQ-029 The redirect SHALL take effect on the edge where the request is sampled, so pc_out shows the target the next cycle (latency 1).

Reset
REQ-030 On a reset edge the block SHALL set:
- pc_out=0x0000_3000 and pc4_out=0x0000_3004.
- pc_bd=0, fetch_adel=0, fetch_cnt=0.
- state=BOOT, so fetch_valid=0.
REQ-031 Reset SHALL override every other input in any state, including mid-stall and mid-REDIR.

Configuration
REQ-032 When macro PC_FETCH_CNT_EN is defined, fetch_cnt SHALL increment by 1 on each edge where fetch_valid=1 and the PC advances or redirects (not stalled, not reset); it wraps 0xFFFF_FFFF->0.
REQ-033 When PC_FETCH_CNT_EN is undefined, the fetch_cnt port SHALL remain present and be tied to constant 0, and no counter logic SHALL be synthesised.

Verification
REQ-034 Reset: assert reset 2 cycles, then release -> pc_out=0x3000 with fetch_valid=0 for 1 cycle, then fetch_valid=1; npc_in=0x3004 -> pc_out=0x3004.
REQ-035 Delay slot and stall: jump_taken=1, npc_in=0x3010 in RUN -> pc_out=0x3010, pc_bd=1; then stall=1 for 3 cycles -> pc_out stays 0x3010, pc_bd stays 1.
REQ-036 Exception during stall: stall=1, exc_req=1 and eret_req=1 together -> pc_out=0x4180, pc_bd=0, state REDIR; next cycle stall=1 and jump_taken=1 are ignored -> pc_out=npc_in, pc_bd=0.
REQ-037 eret: eret_req=1, epc=0x3404 -> pc_out=0x3404, pc_bd=0; eret_req=1, epc=0x3402 -> fetch_adel=1; epc=0x7000 -> fetch_adel=1.
REQ-038 Counter: with PC_FETCH_CNT_EN, run 10 unstalled cycles plus 2 stalled cycles after BOOT -> fetch_cnt=10; without the macro -> fetch_cnt=0 throughout.
REQ-039 Wrap: force npc_in=0xFFFF_FFFC -> pc4_out=0x0000_0000 and fetch_adel=1.
